mmap_arbiter: RTL and testbench
===============================

# mmap_arbiter

Two-port arbiter that shares the single addr/write_en/wdata/rdata port of the DSP register memory map between two requesters: requester 0 (host command interface) and requester 1 (coefficient loader). It registers the winning request, drives exactly one memory-map access per transaction, and returns read data with a valid pulse. It sits directly in front of the memory map inside the DSP top level.

## Interface
- DATA_WIDTH, 16, register width
- NUM_GPR_REGS, 1, number of GPR registers at addresses 0..NUM_GPR_REGS-1
- NUM_COEFFS_REGS, 30, coefficient registers following the GPRs
- ADDR_WIDTH, $clog2(NUM_GPR_REGS+NUM_COEFFS_REGS), memory-map address width
- Ports (N = 0, 1):
- clk  in  1  system clock
- arst_n  in  1  reset, synchronous, active-low
- reqN_valid  in  1  requester N has a transaction
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  target register
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_ready  out  1  transaction accepted this cycle
- reqN_rvalid  out  1  one-cycle read-data valid pulse
- reqN_rdata  out  DATA_WIDTH  read data, held until next read response to N
- reqN_err  out  1  one-cycle error pulse (out-of-range, or protected write)
- filter_active  in  1  FIR currently running (used only with protection)
- mm_addr  out  ADDR_WIDTH  memory-map address
- mm_write_en  out  1  memory-map write strobe
- mm_wdata  out  DATA_WIDTH  memory-map write data
- mm_rdata  in  DATA_WIDTH  memory-map combinational read data

## Operation
- FSM states: IDLE, ACCESS. Reset state IDLE.
- IDLE: if any reqN_valid, select winner, assert its reqN_ready combinationally, latch write/addr/wdata/owner, go to ACCESS. Else stay.
- Arbitration: single requester wins alone; both valid -> grant the one not granted last (round-robin). last_grant resets to 1, so requester 0 wins first contention. last_grant updates only on acceptance.
- ACCESS: drive mm_addr = latched addr. Write: mm_write_en = 1 for this cycle only, mm_wdata = latched data. Read: mm_write_en = 0, capture mm_rdata at end of cycle into owner's reqN_rdata. Always return to IDLE.
- Out-of-range addr (>= NUM_GPR_REGS+NUM_COEFFS_REGS): no mm_write_en; read returns 0; reqN_err pulse to owner.
- Outside ACCESS: mm_write_en = 0, mm_addr/mm_wdata hold last value.
- Requester must hold valid/write/addr/wdata stable until ready; ready never asserts in ACCESS.
- Reset values: all ready/rvalid/err 0, all rdata 0, mm_addr 0, mm_write_en 0, mm_wdata 0, FSM IDLE, last_grant 1.
- Reset asserted mid-ACCESS: next edge forces IDLE, pending write not issued, pending read response discarded.

## Timing
- Accept in cycle T (ready high); memory-map access in T+1; write lands at T+1 clock edge.
- Read: reqN_rvalid and reqN_rdata valid in T+2; reqN_err for any failed transaction also in T+2.
- Throughput: one transaction per 2 cycles; a new accept may occur in T+2, concurrent with previous rvalid.
- Contention: both held valid continuously -> grants alternate 0,1,0,1 every 2 cycles.

## Configuration
- MMAP_COEFF_PROTECT_EN defined: writes to coefficient addresses (NUM_GPR_REGS and above) while filter_active = 1 (sampled at acceptance) are dropped, no mm_write_en, owner gets reqN_err in T+2. GPR writes and all reads unaffected.
- Not defined: filter_active ignored; all in-range writes proceed.

## Structure
- Shared package pak_dsp_pkg: FSM state enum (IDLE, ACCESS), request struct (write, addr, wdata), register-map constants (NUM_GPR_REGS, NUM_COEFFS_REGS, total register count).
- One sub-module: rr_arb2, two-input round-robin grant logic with last_grant register.

## Test plan
- Reset: hold arst_n=0 two cycles -> all outputs 0, state IDLE.
- Req0 write addr 3 data 0x1234 -> ready0 at T, mm_write_en=1 with mm_addr=3 at T+1, no rvalid; subsequent req1 read addr 3 -> rdata1=0x1234, rvalid1 at accept+2.
- Both valid continuously, 4 writes each to addrs 1..4 -> grant order 0,1,0,1,...; mm_write_en every other cycle.
- Req1 read addr 31 (out of range) -> rdata1=0, err1 pulse at T+2, mm_write_en stays 0.
- With MMAP_COEFF_PROTECT_EN, filter_active=1, req0 write addr 5 data 0x00FF -> no strobe, err0 at T+2; write addr 0 -> strobe issued.
- Reset asserted in ACCESS of a write -> mm_write_en 0 after that edge, register not updated on readback.

Source files
------------

// File: rtl/pak_dsp_pkg.sv
// Shared DSP memory-map definitions: register-map sizes, arbiter FSM states
// and the latched request record used by mmap_arbiter.
package pak_dsp_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int NUM_GPR_REGS    = 1;
  localparam int NUM_COEFFS_REGS = 30;
  localparam int NUM_REGS        = NUM_GPR_REGS + NUM_COEFFS_REGS;
  localparam int ADDR_WIDTH      = $clog2(NUM_REGS);

  // Arbiter states: IDLE accepts a request, ACCESS drives the memory map.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mm_state_e;

  // One accepted transaction as seen by the memory map.
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mm_req_t;

  // True when an address lies inside the implemented register map.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < (ADDR_WIDTH + 1)'(NUM_REGS);
  endfunction

endpackage

// File: rtl/mmap_arbiter_rr_arb2.sv
// Two-input round-robin grant logic. A lone requester always wins; on
// contention the requester that was not granted last wins. last_grant starts
// at 1 so requester 0 wins the first contention, and moves only on acceptance.
module rr_arb2 (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant_q;

  // Combinational one-hot grant from the current requests and history.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the most recent winner; only an accepted grant counts.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!arst_n) begin
      last_grant_q <= 1'b1;
    end else if (update) begin
      last_grant_q <= grant[1];
    end
  end

endmodule

// File: rtl/mmap_arbiter.sv
// mmap_arbiter: shares the single DSP memory-map port between the host
// command interface (requester 0) and the coefficient loader (requester 1).
// One transaction per two cycles: accept in IDLE, access in ACCESS, response
// (rvalid/rdata/err) registered one cycle later.
// Optional build macro MMAP_COEFF_PROTECT_EN: drops coefficient writes that
// are accepted while filter_active is high and flags them with reqN_err.
module mmap_arbiter #(
  parameter int DATA_WIDTH      = pak_dsp_pkg::DATA_WIDTH,
  parameter int NUM_GPR_REGS    = pak_dsp_pkg::NUM_GPR_REGS,
  parameter int NUM_COEFFS_REGS = pak_dsp_pkg::NUM_COEFFS_REGS,
  parameter int ADDR_WIDTH      = $clog2(NUM_GPR_REGS + NUM_COEFFS_REGS)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  // requester 0: host command interface
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  // requester 1: coefficient loader
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  // FIR status, consulted only when coefficient protection is built in
  input  logic                  filter_active,
  // memory-map port
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic                  mm_write_en,
  output logic [DATA_WIDTH-1:0] mm_wdata,
  input  logic [DATA_WIDTH-1:0] mm_rdata
);

  import pak_dsp_pkg::*;

  localparam int TOTAL_REGS = NUM_GPR_REGS + NUM_COEFFS_REGS;

  mm_state_e  state_q, state_d;
  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       accept;

  mm_req_t    win_req;
  logic       win_prot;

  mm_req_t    req_q;
  logic       owner_q;
  logic       prot_q;

  logic       addr_ok;
  logic       txn_err;
  logic       access_write;

  assign req_valid = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .arst_n (arst_n),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  // Select the winning requester's transaction fields.
  always_comb begin
    win_req = '0;
    if (grant[1]) begin
      win_req.write = req1_write;
      win_req.addr  = req1_addr;
      win_req.wdata = req1_wdata;
    end else begin
      win_req.write = req0_write;
      win_req.addr  = req0_addr;
      win_req.wdata = req0_wdata;
    end
  end

`ifdef MMAP_COEFF_PROTECT_EN
  // A write aimed at a coefficient while the FIR runs is marked for dropping;
  // filter_active is sampled once, at acceptance.
  assign win_prot = filter_active && win_req.write &&
                    ({1'b0, win_req.addr} >= (ADDR_WIDTH + 1)'(NUM_GPR_REGS));
`else
  logic filter_active_unused;
  assign filter_active_unused = filter_active;
  assign win_prot = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and combinational ready: accept only from IDLE.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the accepted transaction; it also drives mm_addr/mm_wdata, so they
  // hold their last value whenever no new transaction is accepted.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      req_q   <= '0;
      owner_q <= 1'b0;
      prot_q  <= 1'b0;
    end else if (accept) begin
      req_q   <= win_req;
      owner_q <= grant[1];
      prot_q  <= win_prot;
    end
  end

  assign addr_ok      = {1'b0, req_q.addr} < (ADDR_WIDTH + 1)'(TOTAL_REGS);
  assign txn_err      = !addr_ok || prot_q;
  assign access_write = (state_q == ACCESS) && req_q.write && !txn_err;

  assign mm_addr  = req_q.addr;
  assign mm_wdata = req_q.wdata;
  // NOTE: the strobe is gated by the synchronous reset itself so a write whose
  // ACCESS cycle coincides with reset never lands at that edge.
  assign mm_write_en = access_write && arst_n;

  // Register the response to the owner: read data/rvalid and error pulses.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
      if (state_q == ACCESS) begin
        if (!req_q.write) begin
          if (owner_q) begin
            req1_rvalid <= 1'b1;
            req1_rdata  <= addr_ok ? mm_rdata : '0;
          end else begin
            req0_rvalid <= 1'b1;
            req0_rdata  <= addr_ok ? mm_rdata : '0;
          end
        end
        if (txn_err) begin
          if (owner_q) req1_err <= 1'b1;
          else         req0_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmap_arbiter.sv
// Directed self-checking bench for mmap_arbiter with a behavioural memory map.
// Build with MMAP_COEFF_PROTECT_EN to exercise coefficient protection.
module tb_mmap_arbiter;
  import pak_dsp_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        req0_valid, req0_write, req0_ready, req0_rvalid, req0_err;
  logic [4:0]  req0_addr;
  logic [15:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
  logic [4:0]  req1_addr;
  logic [15:0] req1_wdata, req1_rdata;
  logic        filter_active;
  logic [4:0]  mm_addr;
  logic        mm_write_en;
  logic [15:0] mm_wdata, mm_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:31];

  mmap_arbiter dut (
    .clk(clk), .arst_n(arst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .filter_active(filter_active),
    .mm_addr(mm_addr), .mm_write_en(mm_write_en), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata)
  );

  // Behavioural register map: combinational read, write on the clock edge.
  always @(posedge clk) if (mm_write_en) mem[mm_addr] <= mm_wdata;
  assign mm_rdata = mem[mm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected summary before 100us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d);
    req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d);
    req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    int i0, i1, n;
    arst_n = 1'b0;
    filter_active = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);

    // Reset held for two edges.
    tick(); tick(); #2;
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_rvalid0", 32'(req0_rvalid), 0);
    check("rst_rvalid1", 32'(req1_rvalid), 0);
    check("rst_err0", 32'(req0_err), 0);
    check("rst_err1", 32'(req1_err), 0);
    check("rst_rdata0", 32'(req0_rdata), 0);
    check("rst_rdata1", 32'(req1_rdata), 0);
    check("rst_mm_addr", 32'(mm_addr), 0);
    check("rst_mm_we", 32'(mm_write_en), 0);
    check("rst_mm_wdata", 32'(mm_wdata), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    arst_n = 1'b1;

    // Requester 0 writes 0x1234 to address 3.
    tick(); set0(1, 1, 3, 16'h1234); #2;
    check("wr_ready0", 32'(req0_ready), 1);
    check("wr_ready1", 32'(req1_ready), 0);
    check("wr_T_we", 32'(mm_write_en), 0);
    tick(); set0(0, 0, 0, 0); #2;
    check("wr_T1_we", 32'(mm_write_en), 1);
    check("wr_T1_addr", 32'(mm_addr), 3);
    check("wr_T1_wdata", 32'(mm_wdata), 32'h1234);
    check("wr_T1_ready0", 32'(req0_ready), 0);
    // Requester 1 reads address 3 while the write's response slot passes.
    tick(); set1(1, 0, 3, 0); #2;
    check("wr_T2_rvalid0", 32'(req0_rvalid), 0);
    check("wr_T2_err0", 32'(req0_err), 0);
    check("wr_T2_we", 32'(mm_write_en), 0);
    check("rd_ready1", 32'(req1_ready), 1);
    tick(); set1(0, 0, 0, 0); #2;
    check("rd_T1_we", 32'(mm_write_en), 0);
    check("rd_T1_addr", 32'(mm_addr), 3);
    tick(); #2;
    check("rd_T2_rvalid1", 32'(req1_rvalid), 1);
    check("rd_T2_rdata1", 32'(req1_rdata), 32'h1234);
    tick(); #2;
    check("rd_T3_rvalid1", 32'(req1_rvalid), 0);
    check("rd_T3_rdata1_hold", 32'(req1_rdata), 32'h1234);

    // Contention: four writes each to addresses 1..4, grants alternate 0,1.
    i0 = 0; i1 = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      set0(i0 < 4, 1, 5'(i0 + 1), 16'(32'hA000 + i0 + 1));
      set1(i1 < 4, 1, 5'(i1 + 1), 16'(32'hB000 + i1 + 1));
      #2;
      if (k % 2 == 0) begin
        check($sformatf("rr_k%0d_ready0", k), 32'(req0_ready), 32'(k % 4 == 0));
        check($sformatf("rr_k%0d_ready1", k), 32'(req1_ready), 32'(k % 4 == 2));
        check($sformatf("rr_k%0d_we", k), 32'(mm_write_en), 0);
        if (k % 4 == 0) i0++;
        else            i1++;
      end else begin
        n = (k - 1) / 4 + 1;
        check($sformatf("rr_k%0d_we", k), 32'(mm_write_en), 1);
        check($sformatf("rr_k%0d_addr", k), 32'(mm_addr), 32'(n));
        check($sformatf("rr_k%0d_wdata", k), 32'(mm_wdata),
              ((k - 1) % 4 == 0) ? 32'hA000 + 32'(n) : 32'hB000 + 32'(n));
        check($sformatf("rr_k%0d_ready_any", k), 32'({req1_ready, req0_ready}), 0);
      end
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    // Requester 1 wrote last to address 2.
    tick(); set0(1, 0, 2, 0); #2;
    check("rb2_ready0", 32'(req0_ready), 1);
    tick(); set0(0, 0, 0, 0);
    tick(); #2;
    check("rb2_rvalid0", 32'(req0_rvalid), 1);
    check("rb2_rdata0", 32'(req0_rdata), 32'hB002);

    // Out-of-range read by requester 1.
    tick(); set1(1, 0, 31, 0); #2;
    check("oor_ready1", 32'(req1_ready), 1);
    tick(); set1(0, 0, 0, 0); #2;
    check("oor_T1_we", 32'(mm_write_en), 0);
    check("oor_T1_addr", 32'(mm_addr), 31);
    tick(); #2;
    check("oor_T2_err1", 32'(req1_err), 1);
    check("oor_T2_rdata1", 32'(req1_rdata), 0);
    check("oor_T2_we", 32'(mm_write_en), 0);
    tick(); #2;
    check("oor_T3_err1", 32'(req1_err), 0);

    // Coefficient write while the filter runs, then a GPR write.
    filter_active = 1'b1;
    tick(); set0(1, 1, 5, 16'h00FF); #2;
    check("prot_ready0", 32'(req0_ready), 1);
    tick(); set0(0, 0, 0, 0); #2;
`ifdef MMAP_COEFF_PROTECT_EN
    check("prot_coef_we", 32'(mm_write_en), 0);
`else
    check("prot_coef_we", 32'(mm_write_en), 1);
`endif
    tick(); #2;
`ifdef MMAP_COEFF_PROTECT_EN
    check("prot_coef_err0", 32'(req0_err), 1);
`else
    check("prot_coef_err0", 32'(req0_err), 0);
`endif
    tick(); set0(1, 1, 0, 16'h0BEE); #2;
    check("prot_gpr_ready0", 32'(req0_ready), 1);
    tick(); set0(0, 0, 0, 0); #2;
    check("prot_gpr_we", 32'(mm_write_en), 1);
    check("prot_gpr_addr", 32'(mm_addr), 0);
    tick(); #2;
    check("prot_gpr_err0", 32'(req0_err), 0);
    filter_active = 1'b0;

    // Reset lands during the ACCESS cycle of a write.
    tick(); set0(1, 1, 7, 16'h5555);
    tick(); set0(0, 0, 0, 0);
    tick();
    tick(); set0(1, 1, 7, 16'hDEAD); #2;
    check("rstacc_ready0", 32'(req0_ready), 1);
    tick(); set0(0, 0, 0, 0); arst_n = 1'b0; #2;
    check("rstacc_T1_we", 32'(mm_write_en), 0);
    tick(); #2;
    check("rstacc_post_we", 32'(mm_write_en), 0);
    check("rstacc_post_addr", 32'(mm_addr), 0);
    check("rstacc_post_state", 32'(dut.state_q), 32'(IDLE));
    arst_n = 1'b1;
    tick(); set1(1, 0, 7, 0); #2;
    check("rstacc_rd_ready1", 32'(req1_ready), 1);
    tick(); set1(0, 0, 0, 0);
    tick(); #2;
    check("rstacc_rd_rvalid1", 32'(req1_rvalid), 1);
    check("rstacc_rd_rdata1", 32'(req1_rdata), 32'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
